// File: rtl/gray_decode_checker.sv
// Gray-stream decoder and forward-step checker: registers gray words, decodes to binary, flags illegal steps.
// Optional macro GRAY_DEC_STICKY_ERR_EN makes step_err hold until reset.
module gray_decode_checker #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned ERR_CNT_W = 8,
   parameter int unsigned LOCK_CNT  = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 valid_in,
   input  logic [WIDTH-1:0]     gray_in,
   output logic                 bin_valid,
   output logic [WIDTH-1:0]     bin_out,
   output logic                 step_err,
   output logic                 wrap,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic                 locked
);

   typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

   localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

   state_t           state;
   logic             v1;
   logic [WIDTH-1:0] g1;
   logic [WIDTH-1:0] prev_g;
   logic [WIDTH-1:0] prev_b;
   logic [3:0]       good_cnt;

   logic [WIDTH-1:0] bin_c;
   logic [WIDTH-1:0] nb_c;
   int unsigned      dist_c;
   logic             chk_c;
   logic             legal_c;
   logic             err_c;
   logic             wrap_c;
   logic             step_err_nxt;

   // Each binary bit is the parity of the gray bits at and above it.
   always_comb begin
      bin_c = '0;
      for (int unsigned j = 0; j < WIDTH; j++) begin
         bin_c[j] = ^(g1 >> j);
      end
      nb_c    = prev_b + WIDTH'(1);
      dist_c  = $countones(g1 ^ prev_g);
      chk_c   = v1 && (state != IDLE);
      legal_c = chk_c && (dist_c == 1) && (bin_c == nb_c);
      err_c   = chk_c && (dist_c != 0) && !legal_c;
      wrap_c  = legal_c && (prev_b == '1);
   end

`ifdef GRAY_DEC_STICKY_ERR_EN
   assign step_err_nxt = step_err | err_c;
`else
   assign step_err_nxt = err_c;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         v1        <= 1'b0;
         g1        <= '0;
         prev_g    <= '0;
         prev_b    <= '0;
         good_cnt  <= '0;
         bin_valid <= 1'b0;
         bin_out   <= '0;
         step_err  <= 1'b0;
         wrap      <= 1'b0;
         err_count <= '0;
         locked    <= 1'b0;
      end else begin
         v1 <= valid_in;
         if (valid_in) begin
            g1 <= gray_in;
         end

         bin_valid <= v1;
         wrap      <= wrap_c;
         step_err  <= step_err_nxt;

         if (err_c && (err_count != '1)) begin
            err_count <= err_count + ERR_CNT_W'(1);
         end

         if (v1) begin
            bin_out <= bin_c;
            // Reference always follows the latest accepted word, legal or not.
            prev_g  <= g1;
            prev_b  <= bin_c;

            case (state)
               IDLE: begin
                  state    <= TRACK;
                  good_cnt <= '0;
                  locked   <= 1'b0;
               end
               TRACK: begin
                  if (legal_c) begin
                     good_cnt <= good_cnt + 4'd1;
                     if (good_cnt + 4'd1 >= LOCK_TGT) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                     end
                  end else if (err_c) begin
                     good_cnt <= '0;
                  end
               end
               LOCKED: begin
                  if (err_c) begin
                     state    <= TRACK;
                     good_cnt <= '0;
                     locked   <= 1'b0;
                  end
               end
               default: begin
                  state    <= IDLE;
                  good_cnt <= '0;
                  locked   <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_gray_decode_checker.sv
// Self-checking bench for gray_decode_checker: directed vector table, corner sequences, randomized model compare.
// Honours GRAY_DEC_STICKY_ERR_EN when defined for the build.
module tb_gray_decode_checker;

   localparam int W  = 4;
   localparam int EW = 8;
   localparam int LC = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          valid_in;
   logic [W-1:0]  gray_in;
   logic          bin_valid;
   logic [W-1:0]  bin_out;
   logic          step_err;
   logic          wrap;
   logic [EW-1:0] err_count;
   logic          locked;

   int checks = 0;
   int errors = 0;

   gray_decode_checker #(.WIDTH(W), .ERR_CNT_W(EW), .LOCK_CNT(LC)) dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .gray_in(gray_in),
      .bin_valid(bin_valid), .bin_out(bin_out), .step_err(step_err), .wrap(wrap),
      .err_count(err_count), .locked(locked)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: spec-level view (gray value -> integer, distance by popcount, lock by run length).
   bit     m_v1;
   int     m_g1;
   bit     m_ref;
   int     m_pg, m_pb, m_run, m_ecnt;
   bit     m_bv, m_err, m_wrap;
   int     m_bin;

   function automatic int g2b(input int g);
      int b = 0;
      for (int s = 0; s < W; s++) b ^= (g >> s);
      return b & ((1 << W) - 1);
   endfunction

   task automatic model_edge(input bit r, input bit v, input int g);
      bit e;
      int b, d;
      if (r) begin
         m_v1 = 0; m_g1 = 0; m_ref = 0; m_pg = 0; m_pb = 0; m_run = 0; m_ecnt = 0;
         m_bv = 0; m_err = 0; m_wrap = 0; m_bin = 0;
         return;
      end
      e = 0; m_wrap = 0; m_bv = m_v1;
      if (m_v1) begin
         b = g2b(m_g1);
         m_bin = b;
         if (!m_ref) begin
            m_ref = 1; m_run = 0;
         end else begin
            d = $countones(m_g1 ^ m_pg);
            if (d == 1 && b == (m_pb + 1) % (1 << W)) begin
               m_wrap = (m_pb == (1 << W) - 1);
               if (m_run < LC) m_run++;
            end else if (d != 0) begin
               e = 1; m_run = 0;
               if (m_ecnt < (1 << EW) - 1) m_ecnt++;
            end
         end
         m_pg = m_g1; m_pb = b;
      end
`ifdef GRAY_DEC_STICKY_ERR_EN
      m_err = m_err | e;
`else
      m_err = e;
`endif
      m_v1 = v;
      if (v) m_g1 = g;
   endtask

   task automatic tick(input bit r, input bit v, input int g);
      @(negedge clk);
      reset = r; valid_in = v; gray_in = W'(g);
      @(posedge clk);
      model_edge(r, v, g);
      #1;
      chk("bin_valid", bin_valid, m_bv);
      chk("bin_out", bin_out, m_bin);
      chk("step_err", step_err, m_err);
      chk("wrap", wrap, m_wrap);
      chk("err_count", err_count, m_ecnt);
      chk("locked", locked, int'(m_ref && m_run >= LC));
   endtask

   typedef struct {
      int g; int bin; bit wr; bit err; int ecnt; bit lck;
   } vec_t;
   vec_t tbl[27];

   function automatic vec_t mk(int g, int bin, bit wr, bit err, int ecnt, bit lck);
      vec_t t;
      t.g = g; t.bin = bin; t.wr = wr; t.err = err; t.ecnt = ecnt; t.lck = lck;
      return t;
   endfunction

   initial begin
      int ng, cur, wraps;
      bit exp_err;
      reset = 1; valid_in = 0; gray_in = '0;

      // Full forward count and wrap, then LOCKED error/relock, then backward and repeat.
      for (int n = 0; n < 16; n++) tbl[n] = mk(n ^ (n >> 1), n, 0, 0, 0, n >= 4);
      tbl[16] = mk(4'b0000, 0, 1, 0, 0, 1);
      tbl[17] = mk(4'b0001, 1, 0, 0, 0, 1);
      tbl[18] = mk(4'b0010, 3, 0, 1, 1, 0);
      tbl[19] = mk(4'b0110, 4, 0, 0, 1, 0);
      tbl[20] = mk(4'b0111, 5, 0, 0, 1, 0);
      tbl[21] = mk(4'b0101, 6, 0, 0, 1, 0);
      tbl[22] = mk(4'b0100, 7, 0, 0, 1, 1);
      tbl[23] = mk(4'b0011, 2, 0, 1, 2, 0);
      tbl[24] = mk(4'b0001, 1, 0, 1, 3, 0);
      tbl[25] = mk(4'b0011, 2, 0, 0, 3, 0);
      tbl[26] = mk(4'b0011, 2, 0, 0, 3, 0);

      tick(1, 0, 0);
      tick(1, 0, 0);
      chk("rst_bin_valid", bin_valid, 0);
      chk("rst_bin_out", bin_out, 0);
      chk("rst_err_count", err_count, 0);
      chk("rst_locked", locked, 0);

      for (int i = 0; i <= 27; i++) begin
         if (i < 27) tick(0, 1, tbl[i].g);
         else        tick(0, 0, 0);
         if (i > 0) begin
`ifdef GRAY_DEC_STICKY_ERR_EN
            exp_err = (tbl[i-1].ecnt != 0);
`else
            exp_err = tbl[i-1].err;
`endif
            chk($sformatf("tbl%0d_valid", i-1), bin_valid, 1);
            chk($sformatf("tbl%0d_bin", i-1), bin_out, tbl[i-1].bin);
            chk($sformatf("tbl%0d_wrap", i-1), wrap, tbl[i-1].wr);
            chk($sformatf("tbl%0d_err", i-1), step_err, exp_err);
            chk($sformatf("tbl%0d_ecnt", i-1), err_count, tbl[i-1].ecnt);
            chk($sformatf("tbl%0d_lock", i-1), locked, tbl[i-1].lck);
         end
      end

      // Gapped full count: outputs hold and flags stay low in the gaps.
      tick(1, 0, 0);
      wraps = 0;
      for (int n = 0; n <= 16; n++) begin
         tick(0, 1, (n % 16) ^ ((n % 16) >> 1));
         if (wrap) wraps++;
         tick(0, 0, 0);
         if (wrap) wraps++;
      end
      tick(0, 0, 0);
      if (wrap) wraps++;
      chk("gap_wraps", wraps, 1);
      chk("gap_final_bin", bin_out, 0);

      // Saturating error counter.
      tick(1, 0, 0);
      for (int n = 0; n < 260; n++) tick(0, 1, (n % 2) ? 4'b0011 : 4'b0000);
      tick(0, 0, 0);
      tick(0, 0, 0);
      chk("sat_err_count", err_count, 255);

      // Reset with a sample sitting in stage 1 discards it.
      tick(0, 1, 4'b0110);
      tick(1, 1, 4'b0111);
      chk("midrst_valid", bin_valid, 0);
      chk("midrst_bin", bin_out, 0);
      chk("midrst_ecnt", err_count, 0);
      chk("midrst_err", step_err, 0);
      tick(0, 0, 0);
      chk("midrst_discard", bin_valid, 0);

      // Randomized stream against the reference model.
      cur = 0;
      tick(1, 0, 0);
      for (int n = 0; n < 3000; n++) begin
         int sel;
         sel = $urandom_range(0, 99);
         if (sel < 60)      cur = (cur + 1) % 16;
         else if (sel < 75) cur = cur;
         else               cur = $urandom_range(0, 15);
         ng = cur ^ (cur >> 1);
         tick($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 75, ng);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
